// File: rtl/fir_mac.sv
// ---------------------------------------------------------------------------
// fir_mac
//   Four-tap FIR filter built around a single 16x16 multiplier. Each accepted
//   sample runs one multiply-accumulate per tap (taps 0 and 2 add, taps 1 and
//   3 subtract). The signed sum is then saturated to 17 bits and registered
//   as the result.
//
//   A sample is accepted only in IDLE. The FSM walks
//   IDLE -> MAC0 -> MAC1 -> MAC2 -> MAC3 -> DONE -> IDLE. That gives one
//   result every 6 cycles. A new sample can be accepted in the same cycle
//   that result_valid is high.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous active-high reset
//   sample_valid in   1   new sample offered this cycle (honoured in IDLE only)
//   sample_data  in  16   unsigned sample
//   load_coeff   in   1   coefficient write strobe (honoured in IDLE only)
//   coeff_addr   in   2   coefficient index 0..3
//   coeff_data   in  16   unsigned 0.16 fractional coefficient
//   busy         out  1   FSM not in IDLE (combinational)
//   result_valid out  1   one-cycle pulse after the DONE edge
//   result       out 17   saturated two's-complement filter output
//   overflow_err out  1   last result was clipped
// ---------------------------------------------------------------------------
module fir_mac (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  input  logic        load_coeff,
  input  logic [1:0]  coeff_addr,
  input  logic [15:0] coeff_data,
  output logic        busy,
  output logic        result_valid,
  output logic [16:0] result,
  output logic        overflow_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC0,
    S_MAC1,
    S_MAC2,
    S_MAC3,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [15:0]         r_coeff [4];
  logic [15:0]         r_x     [4];
  logic signed [17:0]  r_acc;
  logic [16:0]         r_result;
  logic                r_result_valid;
  logic                r_overflow_err;

  logic [15:0]         w_tap_x;
  logic [15:0]         w_tap_c;
  logic                w_tap_sub;
  logic [31:0]         w_prod;
  logic [15:0]         w_p;
  logic signed [17:0]  w_p_ext;
  logic signed [17:0]  w_acc_mac;
  logic                w_clip_pos;
  logic                w_clip_neg;
  logic [16:0]         w_sat;

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (sample_valid) w_state_next = S_MAC0;
      S_MAC0:  w_state_next = S_MAC1;
      S_MAC1:  w_state_next = S_MAC2;
      S_MAC2:  w_state_next = S_MAC3;
      S_MAC3:  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Tap selection: the current MAC state picks the sample/coefficient pair.
  // Odd taps subtract.
  // ------------------------------------------------------------------------
  always_comb begin
    w_tap_x   = '0;
    w_tap_c   = '0;
    w_tap_sub = 1'b0;
    case (r_state)
      S_MAC0: begin
        w_tap_x = r_x[0];
        w_tap_c = r_coeff[0];
      end
      S_MAC1: begin
        w_tap_x   = r_x[1];
        w_tap_c   = r_coeff[1];
        w_tap_sub = 1'b1;
      end
      S_MAC2: begin
        w_tap_x = r_x[2];
        w_tap_c = r_coeff[2];
      end
      S_MAC3: begin
        w_tap_x   = r_x[3];
        w_tap_c   = r_coeff[3];
        w_tap_sub = 1'b1;
      end
      default: ;
    endcase
  end

  // The coefficient is 0.16 fractional, so the top half of the product is
  // the scaled tap contribution.
  assign w_prod    = w_tap_x * w_tap_c;
  assign w_p       = 16'(w_prod >> 16);
  assign w_p_ext   = $signed({2'b00, w_p});
  assign w_acc_mac = w_tap_sub ? (r_acc - w_p_ext) : (r_acc + w_p_ext);

  // ------------------------------------------------------------------------
  // Saturation to 17-bit signed [-65536, 65535]
  // ------------------------------------------------------------------------
  assign w_clip_pos = (r_acc > 18'sd65535);
  assign w_clip_neg = (r_acc < -18'sd65536);

  always_comb begin
    w_sat = r_acc[16:0];
    if (w_clip_pos) begin
      w_sat = 17'h0FFFF;
    end else if (w_clip_neg) begin
      w_sat = 17'h10000;
    end
  end

  // ------------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_coeff[i] <= '0;
        r_x[i]     <= '0;
      end
      r_acc          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A coefficient write and a sample acceptance on the same edge both
          // land. The MAC pass starts next cycle, so it sees the new value.
          if (load_coeff) begin
            r_coeff[coeff_addr] <= coeff_data;
          end
          if (sample_valid) begin
            r_x[3] <= r_x[2];
            r_x[2] <= r_x[1];
            r_x[1] <= r_x[0];
            r_x[0] <= sample_data;
            r_acc  <= '0;
          end
        end
        S_MAC0, S_MAC1, S_MAC2, S_MAC3: begin
          r_acc <= w_acc_mac;
        end
        S_DONE: begin
          r_result       <= w_sat;
          r_overflow_err <= w_clip_pos | w_clip_neg;
          r_result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign result_valid = r_result_valid;
  assign result       = r_result;
  assign overflow_err = r_overflow_err;

endmodule
